// File: rtl/list_sorter_n.sv
// Streaming top-N sorter: single-cycle insertion into a sorted register list,
// then the kept entries are streamed out in order at frame end.
module list_sorter_n #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned DEPTH   = 4,
   parameter bit          DESCEND = 1'b0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       in_last,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_last,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow
);

   // state   | meaning
   // S_FILL  | accepting samples, inserting each into the sorted list
   // S_DRAIN | streaming the occupied slots out in order
   typedef enum logic {S_FILL, S_DRAIN} state_e;

   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam int unsigned IW = $clog2(DEPTH);
   localparam logic [DATA_W-1:0] SENT = {DATA_W{~DESCEND}};

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   slot_q [DEPTH];
   logic [DATA_W-1:0]   slot_d [DEPTH];
   logic [CW-1:0]       count_q, count_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                overflow_q, overflow_d;
   logic [DEPTH-1:0]    ins;
   logic                full;
   logic                last_beat;

   // ins[i]: the new sample belongs at or before slot i. Empty slots always
   // qualify; strict compare keeps ties behind existing entries.
   always_comb begin
      ins = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ins[i] = (CW'(i) >= count_q) ||
                  (DESCEND ? (in_data > slot_q[i]) : (in_data < slot_q[i]));
      end
   end

   assign full      = (count_q == CW'(DEPTH));
   assign last_beat = (CW'(idx_q) == (count_q - CW'(1)));

   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      count_d    = count_q;
      idx_d      = idx_q;
      overflow_d = overflow_q;
      case (state_q)
         S_FILL: begin
            if (in_valid) begin
               if (ins[0]) slot_d[0] = in_data;
               for (int i = 1; i < DEPTH; i++) begin
                  if (ins[i]) slot_d[i] = ins[i-1] ? slot_q[i-1] : in_data;
               end
               if (full) overflow_d = 1'b1;
               else      count_d    = count_q + CW'(1);
               if (in_last) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (out_ready) begin
               if (last_beat) begin
                  state_d    = S_FILL;
                  count_d    = '0;
                  idx_d      = '0;
                  overflow_d = 1'b0;
                  for (int i = 0; i < DEPTH; i++) slot_d[i] = SENT;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_FILL;
         count_q    <= '0;
         idx_q      <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) slot_q[i] <= SENT;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         overflow_q <= overflow_d;
         for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
      end
   end

   assign in_ready  = (state_q == S_FILL);
   assign out_valid = (state_q == S_DRAIN);
   assign out_data  = (state_q == S_DRAIN) ? slot_q[idx_q] : '0;
   assign out_last  = (state_q == S_DRAIN) && last_beat;
   assign count     = count_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_list_sorter_n.sv
// Directed bench: ascending and descending sorters share one stimulus stream
// and are checked against hand-computed sorted outputs.
module tb_list_sorter_n;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid, in_last, out_ready;
   logic [7:0] in_data;

   logic       in_ready_a, out_valid_a, out_last_a, overflow_a;
   logic [7:0] out_data_a;
   logic [2:0] count_a;
   logic       in_ready_d, out_valid_d, out_last_d, overflow_d;
   logic [7:0] out_data_d;
   logic [2:0] count_d;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   list_sorter_n #(.DATA_W(8), .DEPTH(4), .DESCEND(1'b0)) u_asc (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready_a), .out_valid(out_valid_a),
      .out_data(out_data_a), .out_last(out_last_a), .out_ready(out_ready),
      .count(count_a), .overflow(overflow_a));

   list_sorter_n #(.DATA_W(8), .DEPTH(4), .DESCEND(1'b1)) u_desc (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready_d), .out_valid(out_valid_d),
      .out_data(out_data_d), .out_last(out_last_d), .out_ready(out_ready),
      .count(count_d), .overflow(overflow_d));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; the transfer happens on the following posedge.
   task automatic send(input logic [7:0] d, input logic last);
      check("in_ready_a", 32'(in_ready_a), 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic drain(input string tag, input int n,
                        input logic [7:0] ea [4], input logic [7:0] ed [4]);
      out_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         check({tag, "_valid"},  32'(out_valid_a), 32'd1);
         check({tag, "_data_a"}, 32'(out_data_a),  32'(ea[k]));
         check({tag, "_data_d"}, 32'(out_data_d),  32'(ed[k]));
         check({tag, "_last_a"}, 32'(out_last_a),  32'(k == n - 1));
         check({tag, "_last_d"}, 32'(out_last_d),  32'(k == n - 1));
         @(negedge clk);
      end
      out_ready = 1'b0;
      check({tag, "_rearm"}, 32'(in_ready_a), 32'd1);
      check({tag, "_clr"},   32'({count_a, overflow_a}), 32'd0);
   endtask

   task automatic drain_stats(input string tag, input int cnt, input logic ovf);
      check({tag, "_lat"},   32'(out_valid_a), 32'd1);
      check({tag, "_cnt"},   32'(count_a),     32'(cnt));
      check({tag, "_ovf_a"}, 32'(overflow_a),  32'(ovf));
      check({tag, "_ovf_d"}, 32'(overflow_d),  32'(ovf));
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_count",  32'(count_a),     32'd0);
      check("rst_ovf",    32'(overflow_a),  32'd0);
      check("rst_ovalid", 32'(out_valid_a), 32'd0);
      check("rst_olast",  32'(out_last_a),  32'd0);
      check("rst_odata",  32'(out_data_a),  32'd0);
      check("rst_iready", 32'(in_ready_a),  32'd1);
      reset = 1'b1;

      // basic sort
      send(8'd7, 0); send(8'd3, 0); send(8'd9, 0); send(8'd1, 1);
      drain_stats("t1", 4, 1'b0);
      drain("t1", 4, '{8'd1, 8'd3, 8'd7, 8'd9}, '{8'd9, 8'd7, 8'd3, 8'd1});

      // overflow
      send(8'd50, 0); send(8'd10, 0); send(8'd40, 0);
      send(8'd20, 0); send(8'd30, 0); send(8'd5, 1);
      drain_stats("t2", 4, 1'b1);
      drain("t2", 4, '{8'd5, 8'd10, 8'd20, 8'd30}, '{8'd50, 8'd40, 8'd30, 8'd20});

      // descending keep-largest, then ties
      send(8'd7, 0); send(8'd3, 0); send(8'd9, 0); send(8'd1, 0); send(8'd8, 1);
      drain_stats("t3", 4, 1'b1);
      drain("t3", 4, '{8'd1, 8'd3, 8'd7, 8'd8}, '{8'd9, 8'd8, 8'd7, 8'd3});
      for (int i = 0; i < 5; i++) send(8'd4, i == 4);
      drain_stats("t3tie", 4, 1'b1);
      drain("t3tie", 4, '{8'd4, 8'd4, 8'd4, 8'd4}, '{8'd4, 8'd4, 8'd4, 8'd4});

      // single sample equal to the ascending sentinel
      send(8'hFF, 1);
      drain_stats("t4", 1, 1'b0);
      drain("t4", 1, '{8'hFF, 8'h00, 8'h00, 8'h00}, '{8'hFF, 8'h00, 8'h00, 8'h00});

      // backpressure with ignored input pulses
      send(8'd5, 0); send(8'd2, 0); send(8'd8, 1);
      for (int c = 0; c < 5; c++) begin
         in_valid = c[0];
         in_data  = 8'd0;
         in_last  = c[0];
         check("t5_hold_data", 32'(out_data_a), 32'd2);
         check("t5_hold_last", 32'(out_last_a), 32'd0);
         check("t5_iready",    32'(in_ready_a), 32'd0);
         @(negedge clk);
      end
      in_valid = 1'b0; in_last = 1'b0;
      check("t5_cnt", 32'(count_a), 32'd3);
      drain("t5", 3, '{8'd2, 8'd5, 8'd8, 8'd0}, '{8'd8, 8'd5, 8'd2, 8'd0});
      send(8'd6, 1);
      drain_stats("t5n", 1, 1'b0);
      drain("t5n", 1, '{8'd6, 8'd0, 8'd0, 8'd0}, '{8'd6, 8'd0, 8'd0, 8'd0});

      // reset mid-drain
      send(8'd4, 0); send(8'd3, 0); send(8'd2, 0); send(8'd1, 1);
      out_ready = 1'b1;
      check("t6_b0", 32'(out_data_a), 32'd1);
      @(negedge clk);
      check("t6_b1", 32'(out_data_a), 32'd2);
      @(negedge clk);
      out_ready = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("t6_ovalid", 32'(out_valid_a), 32'd0);
      check("t6_count",  32'(count_a),     32'd0);
      check("t6_ovf",    32'(overflow_a),  32'd0);
      check("t6_iready", 32'(in_ready_a),  32'd1);
      send(8'd2, 0); send(8'd1, 1);
      drain_stats("t6n", 2, 1'b0);
      drain("t6n", 2, '{8'd1, 8'd2, 8'd0, 8'd0}, '{8'd2, 8'd1, 8'd0, 8'd0});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
